rom_loader: RTL and testbench
=============================

# rom_loader

Boot-time loader sitting directly upstream of the 16 KiB byte ROM. It accepts a framed byte stream (2-byte length header, payload, optional checksum) on a valid/ready interface and drives the ROM's init port (`mode`, `sw_addr`, `sw_din`), writing payload bytes to consecutive addresses from 0. While loading it holds the CPU off the ROM; afterwards it reports done/error.

## Interface
- `ADDR_W`, 14: ROM address width; capacity 2^ADDR_W bytes.
- `DATA_W`, 8: byte width; fixed at 8, other values unsupported.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept; a byte transfers on a rising edge with `in_valid && in_ready`.
- `mode`  out  1  ROM init-write strobe, high for exactly the cycles carrying a payload write.
- `sw_addr`  out  ADDR_W  ROM init address.
- `sw_din`  out  8  ROM init data.
- `busy`  out  1  load in progress; the system gates CPU ROM access with it.
- `done`  out  1  load finished; level, held until the next accepted `start` or reset.
- `err`  out  1  load failed; valid while `done`=1.

## Operation
- States: IDLE, HDR_HI, HDR_LO, DATA, CKSUM (macro only), DONE.
- IDLE/DONE + `start` -> HDR_HI; clears `done`, `err`, byte counter, running sum; sets `busy`.
- HDR_HI: accept byte -> store `len_hi`; -> HDR_LO.
- HDR_LO: accept byte; length L = {len_hi[6:0], byte} (15 bits).
- Header check: `len_hi[7]`=1 or L > 2^ADDR_W -> DONE with `err`=1, no ROM writes.
- L = 0 -> CKSUM if macro set (expected sum 0x00), else DONE with `err`=0.
- Otherwise -> DATA.
- DATA: each accepted byte k (0..L-1) is registered to `sw_addr`=k, `sw_din`=byte, `mode`=1 the following cycle; running sum += byte, modulo 256.
- After byte L-1 is accepted -> CKSUM (macro) or DONE.
- `in_ready`=1 exactly in HDR_HI, HDR_LO, DATA, CKSUM; 0 in IDLE and DONE.
- `start` in any other state is ignored.
- `in_valid` in IDLE/DONE is ignored; no transfer occurs.
- `busy`=1 in all states except IDLE and DONE.
- Counter is ADDR_W+1 bits wide, so L = 2^ADDR_W completes without wrap. The last write goes to address 2^ADDR_W-1.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mode`=0, `sw_addr`=0, `sw_din`=0, `busy`=0, `done`=0, `err`=0.
- Throughput: one byte per cycle. With back-to-back payload, `mode` stays high and `sw_addr` increments every cycle.
- Write latency: byte accepted at edge N -> `mode`/`sw_*` valid during cycle N+1 -> ROM writes at edge N+1.
- `mode` drops the cycle after any cycle with no DATA transfer (valid gaps).
- `busy` deasserts and `done` asserts on the same edge that enters DONE. That edge is the one after the final `mode` pulse edge when no checksum is used, so the last ROM write is committed before `busy` falls.
- `sw_addr`/`sw_din` hold their last values when `mode`=0.
- Reset mid-load: immediate return to reset values. ROM bytes already written stay; the rest are undefined. No recovery; a new `start` is needed.

## Configuration
- `ROM_LOADER_CKSUM_EN` defined:
  - After the payload, CKSUM accepts one byte.
  - `err`=1 if it differs from the payload sum mod 256, else 0.
  - DONE is entered on that acceptance.
  - `mode` is never asserted for the checksum byte.
- Not defined: no CKSUM state; `err` is set only by an invalid header.

## Test plan
- Reset, `start`, stream 00 03 AA BB CC (+ checksum 0x31 if macro) -> three `mode` pulses writing addr0=AA, addr1=BB, addr2=CC; `done`=1, `err`=0; CPU readback matches.
- Same frame with `in_valid` toggling every other cycle -> `mode` is high only in the cycle after each transfer; same ROM contents.
- Header 80 05 -> no `mode` pulse; `done`=1, `err`=1 two cycles after the header bytes.
- Header 40 00 (16384) then 16384 bytes -> last write at addr 0x3FFF; no wrap to 0; `done`=1.
- Macro on, frame 00 02 10 20 with checksum 0x31 -> `err`=1; with 0x30 -> `err`=0.
- Assert `rst_n`=0 after 2 of 3 payload bytes -> all outputs return to 0 asynchronously; `start` after release reloads correctly.

Source files
------------

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - framed byte-stream boot loader driving the ROM init port
// Optional trailing checksum byte: define ROM_LOADER_CKSUM_EN
module rom_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mode,
  output logic [ADDR_W-1:0] sw_addr,
  output logic [DATA_W-1:0] sw_din,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter carries one extra bit so a full-capacity load ends without wrapping
  localparam int CW = ADDR_W + 1;

  // FLUSH is a one-cycle drain so the final ROM write commits before busy falls
  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, CKSUM, FLUSH, DONE
  } state_t;

  state_t              state_q;
  logic [7:0]          len_hi_q;
  logic [CW-1:0]       len_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                in_ready_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   sw_addr_q;
  logic [DATA_W-1:0]   sw_din_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
`ifdef ROM_LOADER_CKSUM_EN
  logic [7:0]          sum_q;
`endif

  logic                xfer;
  logic [14:0]         hdr_len;
  logic                hdr_bad;

  assign xfer    = in_valid && in_ready_q;
  assign hdr_len = {len_hi_q[6:0], in_data};
  assign hdr_bad = len_hi_q[7] || (32'(hdr_len) > (32'd1 << ADDR_W));
  assign cnt_d   = cnt_q + CW'(1);

  assign in_ready = in_ready_q;
  assign mode     = mode_q;
  assign sw_addr  = sw_addr_q;
  assign sw_din   = sw_din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  // Loader FSM with all outputs registered; mode is a single-cycle strobe per payload byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      mode_q     <= 1'b0;
      sw_addr_q  <= '0;
      sw_din_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ROM_LOADER_CKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      mode_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= HDR_HI;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ROM_LOADER_CKSUM_EN
            sum_q      <= '0;
`endif
          end
        end
        HDR_HI: begin
          if (xfer) begin
            len_hi_q <= in_data;
            state_q  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            if (hdr_bad) begin
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= FLUSH;
            end else if (hdr_len == '0) begin
`ifdef ROM_LOADER_CKSUM_EN
              state_q    <= CKSUM;
`else
              in_ready_q <= 1'b0;
              state_q    <= FLUSH;
`endif
            end else begin
              len_q   <= CW'(hdr_len);
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            mode_q    <= 1'b1;
            sw_addr_q <= cnt_q[ADDR_W-1:0];
            sw_din_q  <= in_data;
            cnt_q     <= cnt_d;
`ifdef ROM_LOADER_CKSUM_EN
            sum_q     <= sum_q + in_data;
`endif
            if (cnt_d == len_q) begin
`ifdef ROM_LOADER_CKSUM_EN
              state_q    <= CKSUM;
`else
              in_ready_q <= 1'b0;
              state_q    <= FLUSH;
`endif
            end
          end
        end
`ifdef ROM_LOADER_CKSUM_EN
        CKSUM: begin
          if (xfer) begin
            err_q      <= (in_data != sum_q);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
`endif
        FLUSH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mode, busy, done, err;
  logic [13:0] sw_addr;
  logic [7:0]  sw_din;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  logic [21:0] exp_q[$];
  logic [7:0]  rom_m [0:16383];
  logic [7:0]  run_sum;

  always #5 clk = ~clk;

  rom_loader #(.ADDR_W(14), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sw_addr(sw_addr), .sw_din(sw_din),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every mode cycle is a ROM write that must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && mode) begin
      logic [21:0] e;
      n_writes++;
      rom_m[sw_addr] = sw_din;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", sw_addr, sw_din);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {18'd0, sw_addr}, {18'd0, e[21:8]});
        chk("write_data", {24'd0, sw_din}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
  endtask

  task automatic send_data(input logic [13:0] a, input logic [7:0] b);
    exp_q.push_back({a, b});
    run_sum = run_sum + b;
    send(b);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n_writes = 0;
    run_sum  = 8'h00;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic send_cksum(input logic [7:0] c);
`ifdef ROM_LOADER_CKSUM_EN
    send(c);
`else
    if (c == 8'hFF) in_data = 8'h00;
`endif
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mode",     {31'd0, mode},     32'd0);
    chk("rst_sw_addr",  {18'd0, sw_addr},  32'd0);
    chk("rst_sw_din",   {24'd0, sw_din},   32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame 00 03 AA BB CC
    do_start();
    chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    chk("start_busy",     {31'd0, busy},     32'd1);
    send(8'h00); send(8'h03);
    send_data(14'd0, 8'hAA); send_data(14'd1, 8'hBB); send_data(14'd2, 8'hCC);
`ifdef ROM_LOADER_CKSUM_EN
    send(8'h31);
    idle();
`else
    idle();
    chk("last_mode_high", {31'd0, mode}, 32'd1);
    chk("last_busy_high", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
`endif
    wait_done("basic");
    chk("basic_err",    {31'd0, err}, 32'd0);
    chk("basic_writes", n_writes, 32'd3);
    chk("basic_rom0",   {24'd0, rom_m[0]}, 32'hAA);
    chk("basic_rom1",   {24'd0, rom_m[1]}, 32'hBB);
    chk("basic_rom2",   {24'd0, rom_m[2]}, 32'hCC);

    // Valid in DONE is ignored
    @(negedge clk);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    chk("done_no_writes", n_writes, 32'd3);

    // Same frame with gaps between transfers
    rom_m[0] = 8'h00; rom_m[1] = 8'h00; rom_m[2] = 8'h00;
    do_start();
    send(8'h00); idle(); send(8'h03); idle();
    send_data(14'd0, 8'hAA); idle();
    send_data(14'd1, 8'hBB); idle();
    send_data(14'd2, 8'hCC); idle();
    send_cksum(8'h31); idle();
    wait_done("gap");
    chk("gap_err",    {31'd0, err}, 32'd0);
    chk("gap_writes", n_writes, 32'd3);
    chk("gap_rom0",   {24'd0, rom_m[0]}, 32'hAA);
    chk("gap_rom2",   {24'd0, rom_m[2]}, 32'hCC);

    // Header with bit 15 set
    do_start();
    send(8'h80); send(8'h05);
    idle();
    @(negedge clk);
    chk("hdr80_done",   {31'd0, done}, 32'd1);
    chk("hdr80_err",    {31'd0, err},  32'd1);
    chk("hdr80_busy",   {31'd0, busy}, 32'd0);
    chk("hdr80_writes", n_writes, 32'd0);

    // Length one beyond capacity
    do_start();
    send(8'h40); send(8'h01);
    idle();
    wait_done("hdr4001");
    chk("hdr4001_err",    {31'd0, err}, 32'd1);
    chk("hdr4001_writes", n_writes, 32'd0);

    // Zero length
    do_start();
    send(8'h00); send(8'h00);
    send_cksum(8'h00);
    idle();
    wait_done("len0");
    chk("len0_err",    {31'd0, err}, 32'd0);
    chk("len0_writes", n_writes, 32'd0);

`ifdef ROM_LOADER_CKSUM_EN
    // Checksum mismatch and match
    do_start();
    send(8'h00); send(8'h02);
    send_data(14'd0, 8'h10); send_data(14'd1, 8'h20);
    send(8'h31); idle();
    wait_done("cks_bad");
    chk("cks_bad_err", {31'd0, err}, 32'd1);
    do_start();
    send(8'h00); send(8'h02);
    send_data(14'd0, 8'h10); send_data(14'd1, 8'h20);
    send(8'h30); idle();
    wait_done("cks_good");
    chk("cks_good_err", {31'd0, err}, 32'd0);
`endif

    // Full-capacity load
    do_start();
    send(8'h40); send(8'h00);
    for (int k = 0; k < 16384; k++) begin
      logic [13:0] a;
      a = k[13:0];
      send_data(a, a[7:0]);
    end
    send_cksum(run_sum);
    idle();
    wait_done("full");
    chk("full_err",       {31'd0, err}, 32'd0);
    chk("full_writes",    n_writes, 32'd16384);
    chk("full_last_addr", {18'd0, sw_addr}, 32'h3FFF);
    chk("full_last_din",  {24'd0, sw_din}, 32'hFF);
    chk("full_rom_first", {24'd0, rom_m[0]}, 32'h00);
    chk("full_rom_last",  {24'd0, rom_m[16383]}, 32'hFF);

    // Reset mid-load after two of three payload bytes
    do_start();
    send(8'h00); send(8'h03);
    send_data(14'd0, 8'h11); send_data(14'd1, 8'h22);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_mode",     {31'd0, mode},     32'd0);
    chk("mid_rst_sw_addr",  {18'd0, sw_addr},  32'd0);
    chk("mid_rst_sw_din",   {24'd0, sw_din},   32'd0);
    chk("mid_rst_busy",     {31'd0, busy},     32'd0);
    chk("mid_rst_done",     {31'd0, done},     32'd0);
    chk("mid_rst_err",      {31'd0, err},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    send(8'h00); send(8'h03);
    send_data(14'd0, 8'h5A); send_data(14'd1, 8'hA5); send_data(14'd2, 8'h3C);
    send_cksum(run_sum);
    idle();
    wait_done("reload");
    chk("reload_err",    {31'd0, err}, 32'd0);
    chk("reload_writes", n_writes, 32'd3);
    chk("reload_rom0",   {24'd0, rom_m[0]}, 32'h5A);
    chk("reload_rom1",   {24'd0, rom_m[1]}, 32'hA5);
    chk("reload_rom2",   {24'd0, rom_m[2]}, 32'h3C);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
